// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Receive half of the UART. It oversamples the serial line and recovers
// characters of 5 to 8 data bits. Each character has one start bit (0),
// its data bits LSB first, and one stop bit (1). Every received character
// is placed in a parallel register, together with ready, framing-error and
// overrun flags, for the CPU-side read path.
//
// Parameters:
//   OVERSAMPLE  baud cycles per bit (even, >= 4), default 16
//
// Ports:
//   baud       in   1  clock at OVERSAMPLE x bit rate, posedge active
//   rst_n      in   1  asynchronous active-low reset
//   rx         in   1  serial line, asynchronous to baud, idle high
//   re         in   1  receiver enable; new start bits are ignored while low
//   char_size  in   4  data bits per character (clamped to 5..8),
//                      captured when a start bit is detected
//   rd         in   1  read strobe, clears rx_ready and dor
//   data_out   out  8  last received character, zero above the char size
//   rx_ready   out  1  data_out holds a character that has not been read
//   fe         out  1  framing error (stop bit was 0) for data_out
//   dor        out  1  data overrun, a character was lost before rd
//   rx_busy    out  1  a frame is being received
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each sample is the 2-of-3 majority of
//                        the synchronized line over the sample edge and the
//                        two edges before it. This rejects single-cycle
//                        glitches. Sample timing is the same either way.
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       re,
    input  logic [3:0] char_size,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       rx_ready,
    output logic       fe,
    output logic       dor,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);

    // START samples half a bit after the edge, so it lands mid start bit.
    // DATA and STOP then sample one full bit later each time.
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    last_bit_q, last_bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    size_last;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic          sample;
    logic          complete;

    // Two-flop synchronizer for the asynchronous line. rx_prev keeps the
    // previous synchronized value so a falling edge can be detected. All of
    // these reset to the idle (high) level, so a reset never looks like a
    // start bit.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_prev2;

    // One more stage of history so a sample can vote over three
    // consecutive synchronized values.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev2 <= 1'b1;
        end else begin
            rx_prev2 <= rx_prev;
        end
    end

    assign sample = (rx_s & rx_prev) | (rx_s & rx_prev2) | (rx_prev & rx_prev2);
`else
    assign sample = rx_s;
`endif

    // Clamp the requested size to 5..8 and store it as the index of the
    // last data bit, which is what the DATA state compares against.
    always_comb begin
        size_last = 3'd7;
        if (char_size < 4'd5) begin
            size_last = 3'd4;
        end else if (char_size > 4'd8) begin
            size_last = 3'd7;
        end else begin
            size_last = 3'(char_size - 4'd1);
        end
    end

    // State register together with the bit-timing counter, the bit index,
    // the latched character size and the shift register.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_bit_q <= 3'd7;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
        end
    end

    // Next-state logic for the frame. The character size is captured only
    // at start detection, so changing char_size mid-frame has no effect.
    // re only gates new start detection. A frame already in progress runs
    // to completion even if re drops. The shift register is cleared at
    // start so bits above a short character read as zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
        complete   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (re && rx_prev && !rx_s) begin
                    state_d    = START;
                    bit_d      = '0;
                    shift_d    = '0;
                    last_bit_d = size_last;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is already high again mid start bit was
                    // noise. Drop it without touching any flags.
                    state_d = sample ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = sample;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == last_bit_q) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // CPU-facing registers. When a character completes on the same edge as
    // a read, the new character wins: rx_ready stays set, and that
    // character is not counted as an overrun. fe describes whatever is in
    // data_out, so only a new character changes it.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rx_ready <= 1'b0;
            fe       <= 1'b0;
            dor      <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_busy <= (state_d != IDLE);
            if (complete) begin
                data_out <= shift_q;
                fe       <= ~sample;
                rx_ready <= 1'b1;
                dor      <= dor | (rx_ready & ~rd);
            end else if (rd) begin
                rx_ready <= 1'b0;
                dor      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver at OVERSAMPLE=16. Frames are driven on
// the falling edge of baud. A frame-level model predicts, from the start
// edge of each frame, when the frame is busy and when it completes. It also
// tracks the ready, overrun and framing flags, and the outputs are compared
// against it 1 ns after every rising edge. Hand-computed literal
// expectations after each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int OS = 16;

    logic       baud;
    logic       rst_n;
    logic       rx;
    logic       re;
    logic [3:0] char_size;
    logic       rd;
    logic [7:0] data_out;
    logic       rx_ready;
    logic       fe;
    logic       dor;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    // Frame schedule written by the stimulus, read by the model.
    int         sched_e0   = 0;
    int         sched_done = 0;
    logic       sched_on   = 1'b0;
    logic       sched_comp = 1'b0;
    logic [7:0] sched_data = 8'h00;
    logic       sched_fe   = 1'b0;

    // Model state
    int         last_reset_edge = 0;
    int         last_rise = 0;
    logic       prev_ready = 1'b0;
    logic       active;
    logic       m_ready = 1'b0;
    logic       m_dor = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] m_data = 8'h00;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .baud     (baud),
        .rst_n    (rst_n),
        .rx       (rx),
        .re       (re),
        .char_size(char_size),
        .rd       (rd),
        .data_out (data_out),
        .rx_ready (rx_ready),
        .fe       (fe),
        .dor      (dor),
        .rx_busy  (rx_busy)
    );

    initial begin
        baud = 1'b0;
        forever #5 baud = ~baud;
    end

    task automatic checkOutput(input string name, input int act, input int want);
        checks = checks + 1;
        if (act != want) begin
            errors = errors + 1;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, want);
        end
    endtask

    function automatic int effSize(input logic [3:0] cs);
        if (cs < 4'd5) return 5;
        if (cs > 4'd8) return 8;
        return int'(cs);
    endfunction

    // Frame-level model plus per-cycle comparison
    always @(posedge baud) begin
        edge_no = edge_no + 1;
        #1;
        active = sched_on && (sched_e0 > last_reset_edge);
        if (!rst_n) begin
            last_reset_edge = edge_no;
            m_ready = 1'b0;
            m_dor   = 1'b0;
            m_fe    = 1'b0;
            m_data  = 8'h00;
            active  = 1'b0;
        end else if (active && sched_comp && edge_no == sched_done) begin
            m_dor   = m_dor | (m_ready & ~rd);
            m_ready = 1'b1;
            m_data  = sched_data;
            m_fe    = sched_fe;
        end else if (rd) begin
            m_ready = 1'b0;
            m_dor   = 1'b0;
        end
        m_busy = active && (edge_no >= sched_e0 + 2) && (edge_no < sched_done);
        if (rx_ready && !prev_ready) last_rise = edge_no;
        prev_ready = rx_ready;
        checkOutput("rx_ready", int'(rx_ready), int'(m_ready));
        checkOutput("dor", int'(dor), int'(m_dor));
        checkOutput("fe", int'(fe), int'(m_fe));
        checkOutput("rx_busy", int'(rx_busy), int'(m_busy));
        checkOutput("data_out", int'(data_out), int'(m_data));
    end

    // Drive one frame. The start edge E0 is the first rising edge after rx
    // goes low. Completion is expected at E0 + OS/2 + 2 + (n+1)*OS.
    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] cs,
                                 input logic stop_bit, input logic rd_on_done,
                                 input int glitch_bit, output int e0);
        int n;
        int done;
        n = effSize(cs);
        char_size = cs;
        @(negedge baud);
        rx = 1'b0;
        e0 = edge_no + 1;
        done = e0 + OS / 2 + 2 + (n + 1) * OS;
        sched_e0   = e0;
        sched_done = done;
        sched_data = d & 8'((1 << n) - 1);
        sched_fe   = ~stop_bit;
        sched_comp = re;
        sched_on   = re;
        fork
            begin
                repeat (OS) @(negedge baud);
                for (int i = 0; i < n; i++) begin
                    rx = d[i];
                    repeat (OS / 2) @(negedge baud);
                    if (glitch_bit == i) begin
                        rx = ~d[i];
                        @(negedge baud);
                        rx = d[i];
                        repeat (OS / 2 - 1) @(negedge baud);
                    end else begin
                        repeat (OS / 2) @(negedge baud);
                    end
                end
                rx = stop_bit;
                repeat (OS) @(negedge baud);
                rx = 1'b1;
                repeat (3) @(negedge baud);
            end
            begin
                if (rd_on_done) begin
                    repeat (done - e0) @(negedge baud);
                    rd = 1'b1;
                    @(negedge baud);
                    rd = 1'b0;
                end
            end
        join
    endtask

    task automatic pulseRead();
        @(negedge baud);
        rd = 1'b1;
        @(negedge baud);
        rd = 1'b0;
    endtask

    task automatic falseStart(input int low_cycles);
        @(negedge baud);
        rx = 1'b0;
        sched_e0   = edge_no + 1;
        sched_done = edge_no + 1 + OS / 2 + 2;
        sched_comp = 1'b0;
        sched_on   = re;
        repeat (low_cycles) @(negedge baud);
        rx = 1'b1;
        repeat (OS + 4) @(negedge baud);
    endtask

    initial begin
        int e0;
        rst_n = 1'b0;
        rx = 1'b1;
        re = 1'b1;
        rd = 1'b0;
        char_size = 4'd8;

        #2;
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_rx_ready", int'(rx_ready), 0);
        checkOutput("reset_busy", int'(rx_busy), 0);
        repeat (3) @(negedge baud);
        rst_n = 1'b1;
        repeat (5) @(negedge baud);

        $display("[TB] 8-bit frame 0x55");
        applyStimulus(8'h55, 4'd8, 1'b1, 1'b0, -1, e0);
        checkOutput("rise_edge_offset", last_rise - e0, 154);
        checkOutput("data_55", int'(data_out), 8'h55);
        checkOutput("fe_55", int'(fe), 0);
        checkOutput("dor_55", int'(dor), 0);
        pulseRead();

        $display("[TB] short characters");
        applyStimulus(8'h1F, 4'd5, 1'b1, 1'b0, -1, e0);
        checkOutput("data_1F", int'(data_out), 8'h1F);
        pulseRead();
        applyStimulus(8'h00, 4'd5, 1'b1, 1'b0, -1, e0);
        checkOutput("data_00_cs5", int'(data_out), 8'h00);
        pulseRead();
        applyStimulus(8'hFF, 4'd3, 1'b1, 1'b0, -1, e0);
        checkOutput("data_cs3_as_5", int'(data_out), 8'h1F);
        pulseRead();
        applyStimulus(8'hC6, 4'd12, 1'b1, 1'b0, -1, e0);
        checkOutput("data_cs12_as_8", int'(data_out), 8'hC6);
        pulseRead();

        $display("[TB] framing error");
        applyStimulus(8'hA3, 4'd8, 1'b0, 1'b0, -1, e0);
        checkOutput("data_A3", int'(data_out), 8'hA3);
        checkOutput("fe_A3", int'(fe), 1);
        pulseRead();
        checkOutput("fe_kept_after_rd", int'(fe), 1);
        applyStimulus(8'h3C, 4'd8, 1'b1, 1'b0, -1, e0);
        checkOutput("fe_cleared", int'(fe), 0);
        pulseRead();

        $display("[TB] overrun");
        applyStimulus(8'h11, 4'd8, 1'b1, 1'b0, -1, e0);
        applyStimulus(8'h22, 4'd8, 1'b1, 1'b0, -1, e0);
        checkOutput("dor_set", int'(dor), 1);
        checkOutput("data_22", int'(data_out), 8'h22);
        pulseRead();
        checkOutput("ready_after_rd", int'(rx_ready), 0);
        checkOutput("dor_after_rd", int'(dor), 0);
        applyStimulus(8'h33, 4'd8, 1'b1, 1'b0, -1, e0);
        applyStimulus(8'h44, 4'd8, 1'b1, 1'b1, -1, e0);
        checkOutput("ready_rd_coincident", int'(rx_ready), 1);
        checkOutput("dor_rd_coincident", int'(dor), 0);

        $display("[TB] false start");
        falseStart(4);
        checkOutput("false_start_data", int'(data_out), 8'h44);
        checkOutput("false_start_ready", int'(rx_ready), 1);
        checkOutput("false_start_dor", int'(dor), 0);
        pulseRead();

`ifdef UART_RX_MAJORITY_EN
        $display("[TB] glitch rejection");
        applyStimulus(8'h00, 4'd8, 1'b1, 1'b0, 3, e0);
        checkOutput("glitch_data", int'(data_out), 8'h00);
        pulseRead();
`endif

        $display("[TB] receiver disabled");
        re = 1'b0;
        applyStimulus(8'h5A, 4'd8, 1'b1, 1'b0, -1, e0);
        checkOutput("disabled_ready", int'(rx_ready), 0);
        re = 1'b1;

        $display("[TB] reset mid-frame");
        applyStimulus(8'h96, 4'd8, 1'b1, 1'b0, -1, e0);
        @(negedge baud);
        rx = 1'b0;
        sched_e0   = edge_no + 1;
        sched_done = edge_no + 1 + OS / 2 + 2 + 9 * OS;
        sched_data = 8'h00;
        sched_fe   = 1'b0;
        sched_comp = 1'b1;
        sched_on   = 1'b1;
        repeat (40) @(negedge baud);
        rx = 1'b1;
        re = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", int'(rx_busy), 0);
        checkOutput("midreset_ready", int'(rx_ready), 0);
        checkOutput("midreset_data", int'(data_out), 0);
        checkOutput("midreset_fe", int'(fe), 0);
        checkOutput("midreset_dor", int'(dor), 0);
        repeat (3) @(negedge baud);
        rst_n = 1'b1;
        repeat (5) @(negedge baud);
        re = 1'b1;
        applyStimulus(8'h81, 4'd8, 1'b1, 1'b0, -1, e0);
        checkOutput("data_81_after_reset", int'(data_out), 8'h81);
        repeat (4) @(negedge baud);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
